ecc_decode_arbiter: RTL and testbench
=====================================

// Module: ecc_decode_arbiter
// PURPOSE
//  Shares one SEC Hamming `decode` instance (16b data / 21b codeword) between NUM_REQ requesters.
//  Round-robin arbitration issues one codeword per cycle and tracks the decoder latency.
//  Each result returns to the requester that issued it, through a credited result FIFO.
//  Also counts uncorrectable words (dec_valid==0) for status readout.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  DATA_WIDTH   16  decoded data width; matches decode.data_width
//  ENC_WIDTH    21  codeword width; matches decode.encoding_width
//  DEC_LATENCY  1   cycles from dec_encoded_data stable to dec_decoded_data/dec_valid valid (>=1)
//  FIFO_DEPTH   4   result FIFO entries (power of 2, >= DEC_LATENCY+1)
// PORTS
//  clk               in   1                    clock; all state on posedge
//  rstb              in   1                    reset, asynchronous, active-low
//  req_valid         in   NUM_REQ              requester i has a codeword
//  req_encoded       in   NUM_REQ*ENC_WIDTH    codeword i in bits [i*ENC_WIDTH +: ENC_WIDTH]
//  req_ready         out  NUM_REQ              one-hot accept; transfer when req_valid[i]&&req_ready[i]
//  dec_encoded_data  out  ENC_WIDTH            to decode.encoded_data (registered)
//  dec_decoded_data  in   DATA_WIDTH           from decode.decoded_data
//  dec_valid         in   1                    from decode.valid; 1 = correctable or clean
//  rsp_valid         out  NUM_REQ              one-hot; result for requester i at FIFO head
//  rsp_data          out  DATA_WIDTH           corrected data
//  rsp_ok            out  1                    copy of dec_valid for this word
//  rsp_ready         in   NUM_REQ              pop when rsp_valid[i]&&rsp_ready[i]
//  err_clr           in   1                    synchronous clear of err_count
//  err_count         out  16                   saturating count of dec_valid==0 results
// BEHAVIOUR
//  Reset (rstb=0, async):
//   - req_ready, rsp_valid, rsp_data, rsp_ok, dec_encoded_data, err_count = 0.
//   - RR pointer = 0; in-flight pipe and FIFO emptied.
//   - In-flight words are dropped; no response is ever produced for them.
//  Credit:
//   - credit = (inflight_cnt + fifo_cnt) < FIFO_DEPTH.
//   - inflight_cnt counts valid stages of the DEC_LATENCY+1 tag pipe.
//  Arbitration:
//   - Combinational; grant = first i with req_valid[i], searching from rr_ptr upward with wrap.
//   - req_ready = onehot(grant) & {NUM_REQ{credit}}.
//   - req_ready[i] is never asserted without req_valid[i].
//   - On a transfer, rr_ptr <= (grant+1) % NUM_REQ; otherwise rr_ptr holds.
//  Issue (accept at edge T):
//   - dec_encoded_data <= req_encoded[grant] at T.
//   - dec_encoded_data holds its value when there is no transfer.
//   - Tag {vld=1, id=grant} enters the tag pipe at T.
//   - Tag reaches the pipe tail at T+DEC_LATENCY; in that cycle the block samples dec_decoded_data/dec_valid.
//  Capture:
//   - Tail tag valid -> push {id, dec_decoded_data, dec_valid} into the FIFO at edge T+DEC_LATENCY+1.
//   - The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
//  Response:
//   - rsp_valid = fifo_nonempty ? onehot(head.id) : 0.
//   - rsp_data and rsp_ok are driven from head; both read 0 when the FIFO is empty.
//   - Min accept-to-rsp_valid latency is DEC_LATENCY+2 cycles; back-to-back throughput is 1 word/cycle.
//   - Responses leave in issue order; the head blocks until its own requester asserts rsp_ready (head-of-line).
//   - Push and pop in the same cycle are legal at any occupancy, including full.
//  Error count:
//   - On push with dec_valid==0, err_count increments and saturates at 16'hFFFF.
//   - err_clr has priority: if err_clr=1, err_count <= 0 and that cycle's error is not counted.
//  Other:
//   - Pointer wraps: rd/wr pointers are log2(FIFO_DEPTH) bits wide, plus a full/empty count.
//   - Parameter checks: DEC_LATENCY>=1 and FIFO_DEPTH>=DEC_LATENCY+1, checked at elaboration.
// TESTING
//  1 Single req0 with clean codeword for 16'hA5C3, rsp_ready=1:
//    -> rsp_valid=4'b0001 at accept+3, rsp_data=16'hA5C3, rsp_ok=1.
//  2 All 4 req_valid held high, rsp_ready=all 1:
//    -> grants 0,1,2,3,0,... one per cycle; responses return in that id order.
//  3 Single-bit-flipped codeword of 16'h1234 -> rsp_data=16'h1234, rsp_ok=1, err_count unchanged.
//    Double-bit flip -> rsp_ok=0, err_count +1.
//  4 rsp_ready=0 with req0 streaming -> exactly FIFO_DEPTH=4 accepts, then req_ready=0.
//    Raise rsp_ready -> 4 responses drain and issue resumes; no loss or duplication.
//  5 Force 16'hFFFF errors, then one more error -> err_count stays 16'hFFFF.
//    err_clr on the same cycle as an error -> 0.
//  6 Drop rstb with 2 words in flight and 1 in FIFO:
//    -> all outputs 0 immediately; after release, no stale rsp_valid; next req0 -> rsp at +3.

Source files
------------

// File: rtl/ecc_decode_arbiter.sv
// Round-robin arbiter sharing one SEC Hamming decoder among NUM_REQ requesters.
// Tags track decoder latency; each result returns through a credited, in-order FIFO.
module ecc_decode_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ENC_WIDTH   = 21,
  parameter int unsigned DEC_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rstb,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ENC_WIDTH-1:0]   req_encoded,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ENC_WIDTH-1:0]           dec_encoded_data,
  input  logic [DATA_WIDTH-1:0]          dec_decoded_data,
  input  logic                           dec_valid,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_ok,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  input  logic                           err_clr,
  output logic [15:0]                    err_count
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + DEC_LATENCY + 1) + 1;
  localparam int unsigned ERR_W = 16;

  if (DEC_LATENCY < 1) begin : g_chk_lat
    $error("ecc_decode_arbiter: DEC_LATENCY must be >= 1");
  end
  if (FIFO_DEPTH < DEC_LATENCY + 1) begin : g_chk_depth
    $error("ecc_decode_arbiter: FIFO_DEPTH must be >= DEC_LATENCY+1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_pow2
    $error("ecc_decode_arbiter: FIFO_DEPTH must be a power of 2");
  end
  if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_chk_nreq
    $error("ecc_decode_arbiter: NUM_REQ must be 2..8");
  end

  logic [ID_W-1:0]        r_rr_ptr;
  logic [ENC_WIDTH-1:0]   r_dec_enc;
  logic [DEC_LATENCY:0]   r_tag_vld;
  logic [ID_W-1:0]        r_tag_id [DEC_LATENCY+1];
  logic [ID_W-1:0]        r_fifo_id [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  r_fifo_ok;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_fifo_cnt;
  logic [ERR_W-1:0]       r_err_cnt;

  logic [ID_W-1:0]        w_grant;
  logic                   w_any;
  logic [NUM_REQ-1:0]     w_grant_oh;
  logic [ID_W-1:0]        w_rr_next;
  logic [ENC_WIDTH-1:0]   w_sel_enc;
  logic [OCC_W-1:0]       w_inflight;
  logic                   w_credit;
  logic                   w_xfer;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;

  // Requester index at distance ofs above base, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                             input int unsigned ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Round-robin search starting at the pointer.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req_valid[rr_idx(r_rr_ptr, k)]) begin
        w_grant = rr_idx(r_rr_ptr, k);
        w_any   = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_enc = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant == ID_W'(k)) w_sel_enc = req_encoded[k*ENC_WIDTH +: ENC_WIDTH];
    end
  end

  // Words in the tag pipe still hold a FIFO slot, so they count against credit.
  always_comb begin
    w_inflight = '0;
    for (int unsigned s = 0; s <= DEC_LATENCY; s++) begin
      w_inflight = w_inflight + OCC_W'(r_tag_vld[s]);
    end
    w_credit = (w_inflight + OCC_W'(r_fifo_cnt)) < OCC_W'(FIFO_DEPTH);
  end

  assign w_grant_oh = w_any ? (NUM_REQ'(1) << w_grant) : '0;
  assign req_ready  = (rstb && w_credit) ? w_grant_oh : '0;
  assign w_xfer     = |(req_valid & req_ready);
  assign w_rr_next  = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_rr_ptr  <= '0;
      r_dec_enc <= '0;
      r_tag_vld <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[DEC_LATENCY-1:0], w_xfer};
      if (w_xfer) begin
        r_rr_ptr  <= w_rr_next;
        r_dec_enc <= w_sel_enc;
      end
    end
  end

  // Requester ids travel alongside the decoder; validity lives in r_tag_vld.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_grant;
    for (int unsigned s = 1; s <= DEC_LATENCY; s++) begin
      r_tag_id[s] <= r_tag_id[s-1];
    end
  end

  assign dec_encoded_data = r_dec_enc;

  assign w_push  = r_tag_vld[DEC_LATENCY];
  assign w_empty = (r_fifo_cnt == '0);
  assign w_full  = (r_fifo_cnt == CNT_W'(FIFO_DEPTH));

  assign rsp_valid = w_empty ? '0 : (NUM_REQ'(1) << r_fifo_id[r_rd_ptr]);
  assign rsp_data  = w_empty ? '0 : r_fifo_data[r_rd_ptr];
  assign rsp_ok    = !w_empty && r_fifo_ok[r_rd_ptr];
  assign w_pop     = |(rsp_valid & rsp_ready);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // When full, push+pop writes the slot being vacated by the head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]   <= r_tag_id[DEC_LATENCY];
      r_fifo_data[r_wr_ptr] <= dec_decoded_data;
      r_fifo_ok[r_wr_ptr]   <= dec_valid;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_push && !dec_valid && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign err_count = r_err_cnt;

  always @(posedge clk) begin
    if (rstb && w_push && !w_pop) assert (!w_full);
  end

endmodule

// File: tb/tb_ecc_decode_arbiter.sv
// Directed bench for ecc_decode_arbiter with a behavioural 16/21 SEC Hamming decoder
// (one-cycle latency) standing in for the shared decode instance.
module tb_ecc_decode_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned EW = 21;

  logic              clk = 1'b0;
  logic              rstb;
  logic [NR-1:0]     req_valid;
  logic [NR*EW-1:0]  req_encoded;
  logic [NR-1:0]     req_ready;
  logic [EW-1:0]     dec_encoded_data;
  logic [DW-1:0]     dec_decoded_data;
  logic              dec_valid;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ok;
  logic [NR-1:0]     rsp_ready;
  logic              err_clr;
  logic [15:0]       err_count;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] exp_err = 16'h0;

  ecc_decode_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ENC_WIDTH(EW), .DEC_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_encoded(req_encoded), .req_ready(req_ready),
    .dec_encoded_data(dec_encoded_data), .dec_decoded_data(dec_decoded_data),
    .dec_valid(dec_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ok(rsp_ok), .rsp_ready(rsp_ready),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Hamming layout: positions 1..21, parity at powers of two, data elsewhere.
  function automatic logic [20:0] enc(input logic [15:0] d);
    logic [20:0] cw;
    logic        par;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      par = 1'b0;
      for (int p = 1; p <= 21; p++) begin
        if (((p & (1 << b)) != 0) && (p != (1 << b))) par = par ^ cw[p-1];
      end
      cw[(1 << b) - 1] = par;
    end
    return cw;
  endfunction

  // Returns {ok, data}; syndromes beyond position 21 are uncorrectable.
  function automatic logic [16:0] dec(input logic [20:0] cw_in);
    logic [20:0] cw;
    logic [15:0] d;
    int          syn;
    int          j;
    logic        ok;
    cw  = cw_in;
    syn = 0;
    for (int p = 1; p <= 21; p++) begin
      if (cw[p-1]) syn = syn ^ p;
    end
    ok = 1'b1;
    if (syn > 21) ok = 1'b0;
    else if (syn != 0) cw[syn-1] = ~cw[syn-1];
    d = '0;
    j = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p-1];
        j++;
      end
    end
    return {ok, d};
  endfunction

  always_ff @(posedge clk) begin
    {dec_valid, dec_decoded_data} <= dec(dec_encoded_data);
  end

  function automatic logic [3:0] oh(input int i);
    return 4'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one word on a lane with rsp_ready all high; call and return at posedge+1.
  task automatic send_one(input int lane, input logic [15:0] data, input logic [20:0] flip,
                          input logic [15:0] exp_d, input logic exp_ok, input logic chk_d,
                          input string tag);
    int lat;
    req_encoded[lane*EW +: EW] = enc(data) ^ flip;
    req_valid = oh(lane);
    #1;
    chk($sformatf("%s ready", tag), 32'(req_ready), 32'(oh(lane)));
    @(posedge clk); #1;
    req_valid = '0;
    lat = 1;
    while ((rsp_valid == '0) && (lat < 20)) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'd3);
    chk($sformatf("%s rsp_valid", tag), 32'(rsp_valid), 32'(oh(lane)));
    if (chk_d) chk($sformatf("%s rsp_data", tag), 32'(rsp_data), 32'(exp_d));
    chk($sformatf("%s rsp_ok", tag), 32'(rsp_ok), 32'(exp_ok));
    if (!exp_ok && (exp_err != 16'hFFFF)) exp_err = exp_err + 16'd1;
    @(posedge clk); #1;
    chk($sformatf("%s popped", tag), 32'(rsp_valid), 32'd0);
    chk($sformatf("%s err_count", tag), 32'(err_count), 32'(exp_err));
  endtask

  typedef struct {
    int          lane;
    logic [15:0] data;
    logic [20:0] flip;
    logic [15:0] exp_data;
    logic        exp_ok;
    logic        chk_data;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] t2d[4];
  logic [20:0] dbl;
  int          q[$];
  int          nissue, nrsp, acc, stale;
  logic        xfer;

  initial begin
    // Double flip on parity positions 16 and 8: syndrome 24, uncorrectable.
    dbl = 21'h0;
    dbl[15] = 1'b1;
    dbl[7]  = 1'b1;
    vecs[0] = '{0, 16'hA5C3, 21'h000000, 16'hA5C3, 1'b1, 1'b1};
    vecs[1] = '{1, 16'h1234, 21'h000010, 16'h1234, 1'b1, 1'b1};
    vecs[2] = '{2, 16'h1234, 21'h008080, 16'h1234, 1'b0, 1'b1};
    vecs[3] = '{3, 16'h0000, 21'h000000, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{0, 16'hFFFF, 21'h100000, 16'hFFFF, 1'b1, 1'b1};
    vecs[5] = '{1, 16'h8001, 21'h000001, 16'h8001, 1'b1, 1'b1};
    vecs[6] = '{3, 16'hBEEF, 21'h010100, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{2, 16'h5A5A, 21'h080800, 16'h0000, 1'b0, 1'b0};
    t2d[0] = 16'h0F0F; t2d[1] = 16'h3C3C; t2d[2] = 16'h5555; t2d[3] = 16'hAAAA;

    rstb = 1'b0; req_valid = 4'hF; req_encoded = '0; rsp_ready = '0; err_clr = 1'b0;
    #3;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    chk("reset rsp_ok", 32'(rsp_ok), 32'd0);
    chk("reset dec_encoded_data", 32'(dec_encoded_data), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1; rstb = 1'b1; rsp_ready = 4'hF;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      send_one(vecs[i].lane, vecs[i].data, vecs[i].flip, vecs[i].exp_data,
               vecs[i].exp_ok, vecs[i].chk_data, $sformatf("vec%0d", i));
    end

    // All four requesters streaming from a fresh round-robin pointer.
    rstb = 1'b0; exp_err = 16'h0;
    repeat (2) @(posedge clk);
    #1; rstb = 1'b1;
    for (int i = 0; i < 4; i++) req_encoded[i*EW +: EW] = enc(t2d[i]);
    req_valid = 4'hF;
    nissue = 0;
    for (int c = 0; (c < 30) && ((nissue < 8) || (q.size() > 0)); c++) begin
      #1;
      if (req_valid != '0) begin
        chk($sformatf("rr grant%0d", nissue), 32'(req_ready), 32'(oh(nissue % 4)));
        q.push_back(nissue % 4);
        nissue++;
      end
      if ((rsp_valid != '0) && (q.size() > 0)) begin
        chk("rr rsp_valid", 32'(rsp_valid), 32'(oh(q[0])));
        chk("rr rsp_data", 32'(rsp_data), 32'(t2d[q[0]]));
        void'(q.pop_front());
      end
      @(posedge clk); #1;
      if (nissue == 8) req_valid = '0;
    end
    chk("rr drained", 32'(q.size()), 32'd0);
    q.delete();

    // Credit stall with rsp_ready low, then drain and resume.
    rsp_ready = '0; acc = 0; nrsp = 0;
    req_encoded[0 +: EW] = enc(16'h4000);
    req_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      #1;
      xfer = req_ready[0];
      @(posedge clk); #1;
      if (xfer) begin
        acc++;
        req_encoded[0 +: EW] = enc(16'h4000 + 16'(acc));
      end
    end
    #1;
    chk("stall accepts", 32'(acc), 32'd4);
    chk("stall req_ready", 32'(req_ready), 32'd0);
    chk("stall head data", 32'(rsp_data), 32'h4000);
    rsp_ready = 4'hF;
    for (int c = 0; (c < 40) && (nrsp < 8); c++) begin
      #1;
      xfer = req_valid[0] && req_ready[0];
      if (rsp_valid[0]) begin
        chk($sformatf("drain rsp%0d", nrsp), 32'(rsp_data), 32'(16'h4000 + 16'(nrsp)));
        nrsp++;
      end
      @(posedge clk); #1;
      if (xfer) begin
        acc++;
        if (acc < 8) req_encoded[0 +: EW] = enc(16'h4000 + 16'(acc));
        else req_valid = '0;
      end
    end
    chk("drain count", 32'(nrsp), 32'd8);
    chk("resume accepts", 32'(acc), 32'd8);
    repeat (2) @(posedge clk);
    #1;
    chk("drain empty", 32'(rsp_valid), 32'd0);

    // Saturate the error counter with 65536 uncorrectable words.
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr", 32'(err_count), 32'd0);
    req_encoded[0 +: EW] = enc(16'h0000) ^ dbl;
    req_valid = 4'b0001;
    acc = 0;
    for (int c = 0; (c < 70000) && (acc < 65536); c++) begin
      #1;
      if (req_ready[0]) acc++;
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("sat issued", 32'(acc), 32'd65536);
    repeat (6) @(posedge clk);
    #1;
    chk("sat err_count", 32'(err_count), 32'hFFFF);

    // err_clr asserted exactly on the cycle an error word is pushed.
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr-vs-err rsp_ok", 32'(rsp_ok), 32'd0);
    chk("clr-vs-err err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    exp_err = 16'h0;
    send_one(2, 16'h1234, dbl, 16'h1234, 1'b0, 1'b1, "post-clr");

    // Reset with two words in flight and one in the FIFO.
    rsp_ready = '0;
    req_valid = 4'b0001;
    req_encoded[0 +: EW] = enc(16'h6001);
    @(posedge clk); #1;
    req_encoded[0 +: EW] = enc(16'h6002);
    @(posedge clk); #1;
    req_encoded[0 +: EW] = enc(16'h6003);
    @(posedge clk); #1;
    chk("pre-rst rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    rstb = 1'b0; exp_err = 16'h0;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_data", 32'(rsp_data), 32'd0);
    chk("rst rsp_ok", 32'(rsp_ok), 32'd0);
    chk("rst dec_encoded_data", 32'(dec_encoded_data), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1; rstb = 1'b1; rsp_ready = 4'hF;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rsp_valid != '0) stale++;
    end
    chk("post-rst stale rsp", 32'(stale), 32'd0);
    send_one(0, 16'h7E57, 21'h0, 16'h7E57, 1'b1, 1'b1, "post-rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
